alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the tile's 2-cycle pipelined 4-bit ALU (op/A/B in, 8-bit result out).
- Accepts commands {op, a, b} over a valid/ready handshake, buffers them, and issues at most one per cycle to the ALU.
- Tracks in-flight operations through the fixed ALU latency, then returns each result, tagged with its op, over a second valid/ready handshake.
- Uses credit-based issue, so a stalled consumer never causes a lost result; the ALU itself cannot stall.

Parameters:
- LATENCY, 2: cycles from ALU operands driven to result valid on alu_result.
- CMD_DEPTH, 4: command FIFO entries (power of 2).
- RES_DEPTH, 4: result FIFO entries (power of 2); also the credit limit.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  command FIFO can accept.
- in_op  in  3  ALU opcode (000 ADD, 001 SUB, 100 XOR, 101 MUL, 110 SHL1, 111 CMP).
- in_a  in  4  operand A.
- in_b  in  4  operand B.
- alu_op  out  3  registered opcode to ALU.
- alu_a  out  4  registered operand A to ALU.
- alu_b  out  4  registered operand B to ALU.
- alu_issue  out  1  registered; high in cycles where alu_* carry a newly issued command.
- alu_result  in  8  ALU result.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer accepts.
- out_result  out  8  head result.
- out_op  out  3  opcode that produced out_result.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Both FIFOs empty; in-flight tag pipe cleared; outstanding counter = 0.
  - alu_op/alu_a/alu_b = 0, alu_issue = 0, out_valid = 0, out_result = 0, out_op = 0.
  - in_ready is forced 0 while rst is high.
- Accept: a command is written when in_valid & in_ready at an edge. in_ready = !cmd_full & !rst.
  - No write-through when full, even if a pop occurs in the same cycle.
- Issue condition at an edge: cmd FIFO non-empty AND outstanding < RES_DEPTH, where outstanding = in-flight count + result FIFO occupancy.
  - On issue: the FIFO head pops into alu_op/alu_a/alu_b, alu_issue goes to 1 for that cycle, and tag {1, op} enters a LATENCY-deep shift pipe.
  - With no issue: alu_* hold their previous value and alu_issue = 0.
- Capture: a tag exiting the pipe with valid=1 writes {alu_result, op} into the result FIFO at the same edge. alu_result is sampled exactly LATENCY cycles after the cycle alu_issue was high.
- Credit accounting: outstanding +1 on issue, -1 on out_valid & out_ready. Both in one cycle leaves it unchanged.
  - The result FIFO can never overflow, so capture never needs backpressure.
- Latency with empty pipeline: accept at edge E0, issue at E1, capture at E1+LATENCY, out_valid high from E1+LATENCY (3 edges after accept for LATENCY=2).
- Throughput: with out_ready=1, one command accepted, issued and returned per cycle, sustained.
- Ordering: strictly in order; no reordering or dropping.
- Result FIFO: simultaneous capture and pop are legal at any occupancy. out_result/out_op are the registered head entry.
- Arithmetic: opaque to this block. Results pass through unchanged, 8 bits.
- Pointers: wrap modulo depth. Full/empty are distinguished by an extra pointer bit or a count.
- Reset mid-operation: all queued and in-flight commands are discarded. ALU results arriving after reset are ignored because their tags were cleared.

Test Plan:
- Reset then single ADD (op=000, a=3, b=2): alu_op=000, alu_a=3, alu_b=2 with alu_issue=1 one edge after accept; out_valid rises 3 edges after accept with out_result=5, out_op=000.
- Back-to-back MUL 4*3, SUB 9-3, XOR 5^10, SHL1 7, CMP 12>=8 with out_ready=1 and a behavioural 2-cycle ALU model: results 12, 6, 15, 14, 1 in order, on consecutive cycles, with matching out_op.
- out_ready=0, push 10 commands:
  - Exactly 4 are issued, after which alu_issue stays 0.
  - The cmd FIFO holds 4 and in_ready drops after 8 accepts.
  - Raising out_ready yields all 10 results in order with none lost.
- Toggle out_ready 1010… during a 6-command burst: outstanding never exceeds 4, and the result sequence is identical to the unstalled run.
- Assert rst for 1 cycle while 2 commands are in flight and 3 are queued:
  - Next cycle out_valid=0, in_ready=1 and alu_issue=0.
  - No stale result appears.
  - A new ADD 1+1 returns 2.
- Cmd FIFO full with in_valid=1, and a pop occurs in the same cycle: the new command is not accepted that cycle (in_ready=0) and is accepted the next cycle.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, issues them under result-FIFO credit, and returns op-tagged results in order.
module alu_cmd_sequencer #(
  parameter int LATENCY   = 2,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_op,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [2:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_issue,
  input  logic [7:0] alu_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_result,
  output logic [2:0] out_op
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  logic [2:0] c_op [CMD_DEPTH];
  logic [3:0] c_a [CMD_DEPTH];
  logic [3:0] c_b [CMD_DEPTH];
  logic [CW:0] c_wr, c_rd;
  logic [7:0] r_res [RES_DEPTH];
  logic [2:0] r_op [RES_DEPTH];
  logic [RW:0] r_wr, r_rd, outstanding;
  logic [LATENCY-1:0] t_v;
  logic [2:0] t_op [LATENCY];
  logic cmd_empty, cmd_full, push, issue, capture, pop;
  assign cmd_empty  = c_wr == c_rd;
  assign cmd_full   = c_wr == {~c_rd[CW], c_rd[CW-1:0]};
  assign in_ready   = !cmd_full && !rst;
  assign push       = in_valid && in_ready;
  // outstanding counts in-flight plus buffered results, so capture can never overflow
  assign issue      = !cmd_empty && outstanding < (RW+1)'(RES_DEPTH);
  assign capture    = t_v[LATENCY-1];
  assign out_valid  = r_wr != r_rd;
  assign pop        = out_valid && out_ready;
  assign out_result = r_res[r_rd[RW-1:0]];
  assign out_op     = r_op[r_rd[RW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      c_wr        <= '0;
      c_rd        <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      outstanding <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_issue   <= 1'b0;
      t_v         <= '0;
      for (int i = 0; i < LATENCY; i++) t_op[i] <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        r_res[i] <= '0;
        r_op[i]  <= '0;
      end
    end else begin
      if (push) begin
        c_op[c_wr[CW-1:0]] <= in_op;
        c_a[c_wr[CW-1:0]]  <= in_a;
        c_b[c_wr[CW-1:0]]  <= in_b;
        c_wr               <= c_wr + (CW+1)'(1);
      end
      if (issue) begin
        alu_op <= c_op[c_rd[CW-1:0]];
        alu_a  <= c_a[c_rd[CW-1:0]];
        alu_b  <= c_b[c_rd[CW-1:0]];
        c_rd   <= c_rd + (CW+1)'(1);
      end
      alu_issue <= issue;
      t_v[0]    <= issue;
      t_op[0]   <= c_op[c_rd[CW-1:0]];
      for (int i = 1; i < LATENCY; i++) begin
        t_v[i]  <= t_v[i-1];
        t_op[i] <= t_op[i-1];
      end
      if (capture) begin
        r_res[r_wr[RW-1:0]] <= alu_result;
        r_op[r_wr[RW-1:0]]  <= t_op[LATENCY-1];
        r_wr                <= r_wr + (RW+1)'(1);
      end
      if (pop) r_rd <= r_rd + (RW+1)'(1);
      outstanding <= outstanding + (RW+1)'(issue) - (RW+1)'(pop);
    end
  end
endmodule
